// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver with a one-entry receive buffer.
// rx is synchronised with two flops. Each bit is sampled at its mid-point,
// measured from the detected start edge. The received byte is held until the
// consumer pulses read. A dropped byte raises the sticky overrun flag, and a
// low stop bit produces a one-cycle frame_error pulse.
module uart_rx_buffer #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       read,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       overrun,
    output logic       frame_error,
    output logic       busy
);

    localparam int unsigned     CntW        = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntBitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalfLast = CntW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            rx_meta, rx_s;

    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ovr_q, ovr_d;
    logic            fe_q, fe_d;
    logic            deliver;

    // Two-flop synchroniser; it resets to the idle line level so that reset
    // cannot look like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Receiver state, bit timing and shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // Frame decoding. The counter restarts at every state change and at
    // every data-bit boundary.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        deliver   = 1'b0;
        fe_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == CntHalfLast) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        // A line that is high again at mid-start is a glitch.
                        state_d = StIdle;
                    end else begin
                        state_d   = StData;
                        bit_idx_d = '0;
                    end
                end
            end
            StData: begin
                if (cnt_q == CntBitLast) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rx_s;
                    bit_idx_d        = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (cnt_q == CntBitLast) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_d = StIdle;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = StWaitIdle;
                    end
                end
            end
            StWaitIdle: begin
                // A held-low break must not decode as repeated 0x00 frames.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Receive buffer and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            fe_q    <= fe_d;
        end
    end

    // Buffer rules. A read that coincides with a delivery frees the slot for
    // the new byte.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (deliver) begin
            if (!valid_q || read) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                ovr_d   = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (read && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    assign data        = data_q;
    assign data_valid  = valid_q;
    assign overrun     = ovr_q;
    assign frame_error = fe_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer. A short bit period keeps run time
// small. Expected buffer contents come from a small model of the buffer rules.
module tb_uart_rx_buffer;

    localparam int CPB  = 64;
    localparam int HALF = CPB / 2;
    localparam int NOM  = 2 + HALF + 9 * CPB;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic       read  = 1'b0;
    logic [7:0] data;
    logic       data_valid;
    logic       overrun;
    logic       frame_error;
    logic       busy;

    int nerr = 0;
    int nchk = 0;

    // Reference model of the receive buffer
    logic [7:0] exp_data  = 8'h00;
    bit         exp_valid = 1'b0;
    bit         exp_ovr   = 1'b0;

    // Monitors
    int cyc       = 0;
    int start_cyc = 0;
    int rise_cyc  = 0;
    int rise_cnt  = 0;
    int fe_cnt    = 0;
    int fe_wide   = 0;
    bit busy_seen = 1'b0;
    bit prev_valid = 1'b0;
    bit prev_fe    = 1'b0;

    uart_rx_buffer #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .read       (read),
        .data       (data),
        .data_valid (data_valid),
        .overrun    (overrun),
        .frame_error(frame_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid && !prev_valid) begin
            rise_cnt = rise_cnt + 1;
            rise_cyc = cyc;
        end
        if (frame_error) begin
            fe_cnt = fe_cnt + 1;
            if (prev_fe) fe_wide = fe_wide + 1;
        end
        if (busy) busy_seen = 1'b1;
        prev_valid = data_valid;
        prev_fe    = frame_error;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic model_deliver(input logic [7:0] b);
        if (!exp_valid) begin
            exp_data  = b;
            exp_valid = 1'b1;
        end else begin
            exp_ovr = 1'b1;
        end
    endtask

    task automatic model_read();
        if (exp_valid) begin
            exp_valid = 1'b0;
            exp_ovr   = 1'b0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_read();
        read = 1'b1;
        tick(1);
        read = 1'b0;
        model_read();
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        rx        = 1'b0;
        start_cyc = cyc;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_ok;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        nchk++; if (data !== 8'h00) begin nerr++;
            $display("FAIL %s_data: got %h want 00", tag, data); end
        nchk++; if (data_valid !== 1'b0) begin nerr++;
            $display("FAIL %s_valid: got %b want 0", tag, data_valid); end
        nchk++; if (overrun !== 1'b0) begin nerr++;
            $display("FAIL %s_overrun: got %b want 0", tag, overrun); end
        nchk++; if (frame_error !== 1'b0) begin nerr++;
            $display("FAIL %s_frame_error: got %b want 0", tag, frame_error); end
        nchk++; if (busy !== 1'b0) begin nerr++;
            $display("FAIL %s_busy: got %b want 0", tag, busy); end
    endtask

    task automatic check_buffer(input string tag);
        nchk++; if (data_valid !== exp_valid) begin nerr++;
            $display("FAIL %s_valid: got %b want %b", tag, data_valid, exp_valid); end
        nchk++; if (overrun !== exp_ovr) begin nerr++;
            $display("FAIL %s_overrun: got %b want %b", tag, overrun, exp_ovr); end
        if (exp_valid) begin
            nchk++; if (data !== exp_data) begin nerr++;
                $display("FAIL %s_data: got %h want %h", tag, data, exp_data); end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        check_outputs_zero("reset");
        reset = 1'b1;
        tick(4);
    endtask

    task automatic test_single();
        int r0, f0, lat;
        r0 = rise_cnt;
        f0 = fe_cnt;
        send_frame(8'hA5, 1'b1);
        model_deliver(8'hA5);
        tick(CPB);
        nchk++; if (rise_cnt !== r0 + 1) begin nerr++;
            $display("FAIL single_deliveries: got %0d want %0d", rise_cnt - r0, 1); end
        lat = rise_cyc - start_cyc;
        nchk++; if (lat < NOM - 3 || lat > NOM + 3) begin nerr++;
            $display("FAIL single_latency: got %0d want %0d+-3", lat, NOM); end
        check_buffer("single");
        nchk++; if (fe_cnt !== f0) begin nerr++;
            $display("FAIL single_frame_error: got %0d want 0 pulses", fe_cnt - f0); end
        nchk++; if (busy !== 1'b0) begin nerr++;
            $display("FAIL single_busy: got %b want 0", busy); end
        pulse_read();
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'h3C;
        fork
            begin
                for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    int t;
                    t = 0;
                    while (data_valid !== 1'b1 && t < 12 * CPB) begin
                        tick(1);
                        t++;
                    end
                    nchk++; if (t >= 12 * CPB) begin nerr++;
                        $display("FAIL b2b_wait%0d: got timeout want data_valid", i); end
                    model_deliver(bytes[i]);
                    tick(10);
                    check_buffer("b2b");
                    pulse_read();
                    check_buffer("b2b_after_read");
                end
            end
        join
        tick(CPB);
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1);
        model_deliver(8'h11);
        tick(2);
        send_frame(8'h22, 1'b1);
        model_deliver(8'h22);
        tick(CPB);
        check_buffer("overrun");
        nchk++; if (overrun !== 1'b1) begin nerr++;
            $display("FAIL overrun_set: got %b want 1", overrun); end
        pulse_read();
        check_buffer("overrun_read");
    endtask

    task automatic test_frame_error();
        int r0, f0;
        r0 = rise_cnt;
        f0 = fe_cnt;
        send_frame(8'h55, 1'b0);
        tick(2 * CPB);
        nchk++; if (fe_cnt !== f0 + 1) begin nerr++;
            $display("FAIL fe_pulses: got %0d want 1", fe_cnt - f0); end
        nchk++; if (rise_cnt !== r0) begin nerr++;
            $display("FAIL fe_deliveries: got %0d want 0", rise_cnt - r0); end
        check_buffer("fe");
        send_frame(8'h81, 1'b1);
        model_deliver(8'h81);
        tick(CPB);
        check_buffer("fe_next");
        pulse_read();
    endtask

    task automatic test_glitch_break();
        int r0, f0;
        r0 = rise_cnt;
        f0 = fe_cnt;
        busy_seen = 1'b0;
        rx = 1'b0;
        tick(CPB / 4);
        rx = 1'b1;
        tick(CPB);
        nchk++; if (busy_seen !== 1'b1) begin nerr++;
            $display("FAIL glitch_busy_seen: got %b want 1", busy_seen); end
        nchk++; if (busy !== 1'b0) begin nerr++;
            $display("FAIL glitch_busy_end: got %b want 0", busy); end
        nchk++; if (rise_cnt !== r0 || fe_cnt !== f0) begin nerr++;
            $display("FAIL glitch_events: got %0d/%0d want 0/0", rise_cnt - r0, fe_cnt - f0); end
        rx = 1'b0;
        tick(20 * CPB);
        rx = 1'b1;
        tick(2 * CPB);
        nchk++; if (fe_cnt !== f0 + 1) begin nerr++;
            $display("FAIL break_pulses: got %0d want 1", fe_cnt - f0); end
        nchk++; if (rise_cnt !== r0) begin nerr++;
            $display("FAIL break_deliveries: got %0d want 0", rise_cnt - r0); end
        nchk++; if (busy !== 1'b0) begin nerr++;
            $display("FAIL break_busy: got %b want 0", busy); end
    endtask

    task automatic test_mid_reset();
        int r0;
        logic [7:0] b;
        b  = 8'hC3;
        r0 = rise_cnt;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = b[4];
        tick(CPB / 2);
        reset = 1'b0;
        rx    = 1'b1;
        tick(2);
        check_outputs_zero("midreset");
        tick(3);
        reset     = 1'b1;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
        exp_data  = 8'h00;
        tick(2 * CPB);
        nchk++; if (rise_cnt !== r0) begin nerr++;
            $display("FAIL midreset_partial: got %0d want 0 deliveries", rise_cnt - r0); end
        send_frame(8'h7E, 1'b1);
        model_deliver(8'h7E);
        tick(CPB);
        nchk++; if (rise_cnt !== r0 + 1) begin nerr++;
            $display("FAIL midreset_deliveries: got %0d want 1", rise_cnt - r0); end
        check_buffer("midreset_next");
        pulse_read();
    endtask

    task automatic test_random();
        int f0, exp_fe;
        f0     = fe_cnt;
        exp_fe = 0;
        for (int i = 0; i < 10; i++) begin
            logic [7:0] b;
            bit         ok;
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 4) != 0);
            send_frame(b, ok);
            if (ok) model_deliver(b);
            else exp_fe++;
            check_buffer("random");
            if ($urandom_range(0, 1) == 1) pulse_read();
            tick($urandom_range(0, CPB));
            if (!ok) tick(CPB);
        end
        tick(CPB);
        nchk++; if (fe_cnt !== f0 + exp_fe) begin nerr++;
            $display("FAIL random_fe: got %0d want %0d", fe_cnt - f0, exp_fe); end
        pulse_read();
        check_buffer("random_drain");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_frame_error();
        test_glitch_break();
        test_mid_reset();
        test_random();
        nchk++; if (fe_wide !== 0) begin nerr++;
            $display("FAIL fe_width: got %0d wide pulses want 0", fe_wide); end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
